// File: rtl/mc_ctrl_hs.sv
// mc_ctrl_hs: multicycle RV32I control FSM with request/ack memory handshakes,
// a bus timeout that converts a silent bus into an access fault, and optional
// sequencing of a multi-cycle M-extension unit.
//
// Handshake: imem_req/dmem_req are registered and rise on the edge that enters
// the wait state. They stay high, together with dmem_we, until the cycle in which
// ack, err or timeout is seen, and they fall on the following edge. In that cycle
// err wins over ack, and ack wins over timeout. An ack or err that arrives while
// no request is outstanding is ignored.
module mc_ctrl_hs #(
    parameter int HAS_MDU     = 1,
    parameter int BUS_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] inst,
    input  logic [31:0] mem_addr,
    input  logic        take_branch,
    input  logic        trap_pending,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic        imem_err,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    input  logic        dmem_err,
    output logic        mdu_start,
    input  logic        mdu_done,
    output logic        ir_write,
    output logic        pc_write,
    output logic        reg_write,
    output logic        csr_write,
    output logic        trap_start,
    output logic        trap_finish,
    output logic        illegal_inst,
    output logic        env_call,
    output logic        env_break,
    output logic        inst_addr_misalign,
    output logic        load_addr_misalign,
    output logic        store_addr_misalign,
    output logic        inst_access_fault,
    output logic        load_access_fault,
    output logic        store_access_fault,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        S_FETCH, S_IWAIT, S_EXECUTE, S_MDU, S_DWAIT, S_WB, S_TRAP
    } state_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // Counter only has to reach BUS_TIMEOUT; it is cleared when the wait ends.
    localparam int CW = $clog2(BUS_TIMEOUT + 2);

    state_t          state, state_n;
    logic [CW-1:0]   to_cnt;
    logic            to_hit;
    logic            ls_misalign;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [11:0]     sys_imm;
    logic            unused_bits;

    assign opcode    = inst[6:0];
    assign funct3    = inst[14:12];
    assign funct7    = inst[31:25];
    assign sys_imm   = inst[31:20];
    assign state_dbg = state;
    assign unused_bits = ^{inst[19:15], inst[11:7], mem_addr[31:2]};

    // funct3[1:0]: 00 byte, 01 half, 10 word (bit 2 only selects sign extension).
    assign ls_misalign = ((funct3[1:0] == 2'b10) && (mem_addr[1:0] != 2'b00)) ||
                         ((funct3[1:0] == 2'b01) && mem_addr[0]);

    assign to_hit = (BUS_TIMEOUT != 0) && (to_cnt == CW'(BUS_TIMEOUT));

    // State, registered bus requests and the wait-cycle counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_FETCH;
            imem_req <= 1'b0;
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            to_cnt   <= '0;
        end else begin
            state    <= state_n;
            imem_req <= (state_n == S_IWAIT);
            dmem_req <= (state_n == S_DWAIT);
            dmem_we  <= (state_n == S_DWAIT) &&
                        ((state == S_DWAIT) ? dmem_we : (opcode == OPC_STORE));
            if ((state_n == state) && ((state == S_IWAIT) || (state == S_DWAIT)))
                to_cnt <= to_cnt + 1'b1;
            else
                to_cnt <= '0;
        end
    end

    // Next state and single-cycle strobes; exceptions never set a write strobe.
    always_comb begin
        state_n             = state;
        mdu_start           = 1'b0;
        ir_write            = 1'b0;
        pc_write            = 1'b0;
        reg_write           = 1'b0;
        csr_write           = 1'b0;
        trap_start          = 1'b0;
        trap_finish         = 1'b0;
        illegal_inst        = 1'b0;
        env_call            = 1'b0;
        env_break           = 1'b0;
        inst_addr_misalign  = 1'b0;
        load_addr_misalign  = 1'b0;
        store_addr_misalign = 1'b0;
        inst_access_fault   = 1'b0;
        load_access_fault   = 1'b0;
        store_access_fault  = 1'b0;
        case (state)
            S_FETCH: state_n = trap_pending ? S_TRAP : S_IWAIT;
            S_IWAIT: begin
                if (imem_err) begin
                    inst_access_fault = 1'b1;
                    state_n = S_FETCH;
                end else if (imem_ack) begin
                    ir_write = 1'b1;
                    state_n = S_EXECUTE;
                end else if (to_hit) begin
                    inst_access_fault = 1'b1;
                    state_n = S_FETCH;
                end
            end
            S_EXECUTE: begin
                state_n = S_FETCH;
                case (opcode)
                    OPC_LUI, OPC_AUIPC, OPC_IMM: begin
                        pc_write = 1'b1;
                        reg_write = 1'b1;
                    end
                    OPC_OP: begin
                        if (funct7 == 7'b0000001) begin
                            if (HAS_MDU != 0) begin
                                mdu_start = 1'b1;
                                state_n = S_MDU;
                            end else begin
                                illegal_inst = 1'b1;
                            end
                        end else begin
                            pc_write = 1'b1;
                            reg_write = 1'b1;
                        end
                    end
                    OPC_JAL, OPC_JALR: begin
                        if ((opcode == OPC_JAL) ? (mem_addr[1:0] != 2'b00) : mem_addr[1]) begin
                            inst_addr_misalign = 1'b1;
                        end else begin
                            pc_write = 1'b1;
                            reg_write = 1'b1;
                        end
                    end
                    OPC_BRANCH: begin
                        if (take_branch && (mem_addr[1:0] != 2'b00))
                            inst_addr_misalign = 1'b1;
                        else
                            pc_write = 1'b1;
                    end
                    OPC_FENCE: pc_write = 1'b1;
                    OPC_LOAD: begin
                        if (ls_misalign) load_addr_misalign = 1'b1;
                        else state_n = S_DWAIT;
                    end
                    OPC_STORE: begin
                        if (ls_misalign) store_addr_misalign = 1'b1;
                        else state_n = S_DWAIT;
                    end
                    OPC_SYSTEM: begin
                        if (funct3 == 3'b000) begin
                            case (sys_imm)
                                12'h000: env_call = 1'b1;
                                12'h001: env_break = 1'b1;
                                12'h302: begin
                                    trap_finish = 1'b1;
                                    pc_write = 1'b1;
                                end
                                12'h105: pc_write = 1'b1;
                                default: illegal_inst = 1'b1;
                            endcase
                        end else begin
                            csr_write = 1'b1;
                            reg_write = 1'b1;
                            pc_write = 1'b1;
                        end
                    end
                    default: illegal_inst = 1'b1;
                endcase
            end
            S_MDU: begin
                if (mdu_done) begin
                    reg_write = 1'b1;
                    pc_write = 1'b1;
                    state_n = S_FETCH;
                end
            end
            S_DWAIT: begin
                if (dmem_err || (!dmem_ack && to_hit)) begin
                    load_access_fault = !dmem_we;
                    store_access_fault = dmem_we;
                    state_n = S_FETCH;
                end else if (dmem_ack) begin
                    pc_write = dmem_we;
                    state_n = dmem_we ? S_FETCH : S_WB;
                end
            end
            S_WB: begin
                reg_write = 1'b1;
                pc_write = 1'b1;
                state_n = S_FETCH;
            end
            S_TRAP: begin
                trap_start = 1'b1;
                pc_write = 1'b1;
                state_n = S_FETCH;
            end
            default: state_n = S_FETCH;
        endcase
    end

endmodule

// File: doc/mc_ctrl_hs.md
Name: mc_ctrl_hs

Overview:
Multicycle RV32I control FSM with valid/ack handshakes on the instruction and data memory ports. It replaces fixed single-cycle memory strobes with request-hold-until-ack, and adds a bus timeout that raises access faults. It optionally sequences a multi-cycle M-extension unit (MDU). It sits between the fetch/decode datapath, the memory bus adapters, the MDU and the CSR/trap unit.

Parameters:
HAS_MDU, 1, 1 = decode OP with funct7=0000001 as MDU op; 0 = those encodings are illegal_inst.
BUS_TIMEOUT, 16, max wait cycles for ack before access fault; 0 disables the timeout.

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
inst  in  32  current instruction register
mem_addr  in  32  computed target/data address from the datapath
take_branch  in  1  branch condition result
trap_pending  in  1  CSR unit has a latched exception/interrupt
imem_req  out  1  registered; fetch request, held until ack/err/timeout
imem_ack  in  1  fetch data valid
imem_err  in  1  fetch bus error
dmem_req  out  1  registered; data request, held until ack/err/timeout
dmem_we  out  1  registered; 1 = store, qualified by dmem_req
dmem_ack  in  1  data access complete
dmem_err  in  1  data bus error
mdu_start  out  1  one-cycle MDU launch pulse
mdu_done  in  1  MDU result valid
ir_write, pc_write, reg_write, csr_write  out  1 each  datapath strobes
trap_start, trap_finish  out  1 each  enter trap / MRET
illegal_inst, env_call, env_break  out  1 each  exception pulses
inst_addr_misalign, load_addr_misalign, store_addr_misalign  out  1 each  exception pulses
inst_access_fault, load_access_fault, store_access_fault  out  1 each  exception pulses

Behaviour:
- Reset: state=FETCH; imem_req=dmem_req=dmem_we=0; timeout counter=0. All combinational strobes are 0 in reset and in FETCH.
- States: FETCH, IWAIT, EXECUTE, MDU, DWAIT, WB, TRAP.
- FETCH: trap_pending -> TRAP. Otherwise set imem_req on the edge and go to IWAIT.
- IWAIT: imem_err -> inst_access_fault, drop req, go to FETCH. imem_ack -> ir_write, drop req, go to EXECUTE. Timeout -> inst_access_fault, go to FETCH.
  - Error beats ack when both arrive in the same cycle.
  - Ack beats timeout when both arrive in the same cycle.
- Timeout counter: cleared on entry to IWAIT/DWAIT; increments each wait cycle with no ack/err. Fault fires when count==BUS_TIMEOUT, i.e. the (BUS_TIMEOUT+1)th wait cycle.
- EXECUTE, by opcode:
  - LUI/AUIPC/OP_IMM/OP: pc_write + reg_write.
  - JAL: misaligned if mem_addr[1:0]!=0. JALR: misaligned if mem_addr[1]!=0. BRANCH: misaligned if take_branch && mem_addr[1:0]!=0.
  - FENCE: pc_write.
  - LOAD/STORE: misaligned if WORD and mem_addr[1:0]!=0, or HALF and mem_addr[0]!=0. If aligned, set dmem_req (dmem_we=STORE) and go to DWAIT.
  - OP with funct7=0000001 and HAS_MDU=1: mdu_start, go to MDU.
  - SYSTEM, func3=0: 0x000 -> env_call; 0x001 -> env_break; 0x302 -> trap_finish + pc_write; 0x105 (WFI) -> pc_write as NOP; any other value -> illegal_inst.
  - SYSTEM, func3!=0: csr_write + reg_write + pc_write.
  - Any other opcode: illegal_inst.
- Any exception pulse in EXECUTE suppresses pc_write, reg_write, csr_write, dmem_req and mdu_start, and forces next state = FETCH. The CSR unit raises trap_pending, so FETCH goes on to TRAP.
- MDU: wait in MDU until mdu_done, then reg_write + pc_write and go to FETCH. No timeout in MDU.
- DWAIT:
  - dmem_err -> load_access_fault or store_access_fault, go to FETCH.
  - dmem_ack, store -> pc_write, go to FETCH.
  - dmem_ack, load -> go to WB.
  - Timeout -> matching access fault, go to FETCH.
  - Request is dropped on leaving DWAIT.
- WB: reg_write + pc_write, go to FETCH.
- TRAP: trap_start + pc_write, go to FETCH.
- Every combinational strobe is a single-cycle pulse.
- Async reset mid-transaction drops the request immediately. The bus adapter must discard any late ack.

Test Plan:
- ADDI with imem_ack after 3 wait cycles -> imem_req high for 3 cycles + ack cycle; ir_write 1 cycle; pc_write+reg_write in EXECUTE; back in FETCH.
- LW at 0x1002 -> load_addr_misalign pulse, dmem_req never rises, no reg_write; with trap_pending=1 in FETCH -> TRAP, trap_start+pc_write.
- SW at 0x1000, dmem_ack after 5 cycles -> dmem_req=dmem_we=1 for 5 cycles, pc_write on the ack cycle, no reg_write.
- BUS_TIMEOUT=4, imem never acks -> inst_access_fault in the 5th IWAIT cycle, imem_req drops the next edge.
- MUL with HAS_MDU=1, mdu_done after 32 cycles -> mdu_start 1 cycle, reg_write+pc_write on the done cycle. With HAS_MDU=0 -> illegal_inst, no writes.
- imem_ack and imem_err in the same cycle -> inst_access_fault, no ir_write. Assert rst_n low during DWAIT -> dmem_req=0 immediately, state FETCH.
